// File: rtl/output_split_block.sv
// rtl/output_split_block.sv - steers merged router packets into per-destination output FIFOs
//
// Purpose:
//   Receive-side splitter. Each packet on the merged input stream carries a
//   3-bit destination field at in_data[DEST_MSB -: 3].
//     - Codes 0-3 go to port FIFOs 0-3.
//     - Code 4 goes to the core FIFO (index 4).
//     - Codes 5-7 are dropped and counted in a saturating counter.
//   Each destination owns a DEPTH-entry FIFO, so one stalled output does not
//   stop traffic to the others. The exception is a packet at the shared input
//   head whose own FIFO is full.
//
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   in_valid    merged input packet valid
//   in_data     merged input packet (WIDTH bits)
//   in_ready    input accepted when in_valid && in_ready
//   out_valid   per-destination valid (bits 0-3 ports, bit 4 core)
//   out_data    per-destination packet, slice i = [i*WIDTH +: WIDTH]
//   out_ready   per-destination ready
//   drop_count  saturating count of packets with an invalid destination
//   pkt_count   (SPLIT_STATS_EN only) 5 x 16-bit wrapping pop counters
//
// Optional feature macro: SPLIT_STATS_EN

module output_split_block #(
  parameter int WIDTH    = 11,
  parameter int DEST_MSB = 10,
  parameter int DEPTH    = 2,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic [4:0]           out_valid,
  output logic [5*WIDTH-1:0]   out_data,
  input  logic [4:0]           out_ready,
  output logic [CNT_W-1:0]     drop_count
`ifdef SPLIT_STATS_EN
  ,
  output logic [5*16-1:0]      pkt_count
`endif
);

  localparam int             PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [2:0]       dest;
  logic             dest_ok;
  logic             accept;
  logic [4:0]       full;
  logic [4:0]       push;
  logic [4:0]       pop;
  logic [CNT_W-1:0] drop_q;
  logic [CNT_W-1:0] drop_d;

  assign dest    = in_data[DEST_MSB -: 3];
  assign dest_ok = (dest <= 3'd4);

  // in_ready looks only at the destination code and FIFO occupancy, never at
  // out_ready. A full FIFO therefore refuses a packet even when it is being
  // popped in the same cycle.
  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (dest_ok) begin
        in_ready = !full[dest];
      end else begin
        in_ready = 1'b1;
      end
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    drop_d = drop_q;
    if (accept && !dest_ok && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;

  for (genvar g = 0; g < 5; g++) begin : g_fifo
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W:0]   cnt_q;
    logic [PTR_W:0]   cnt_d;

    assign push[g]      = accept && dest_ok && (dest == 3'(g));
    assign pop[g]       = out_valid[g] && out_ready[g];
    assign full[g]      = (cnt_q == FULL_CNT);
    assign out_valid[g] = (cnt_q != '0);

    // Head is read straight from storage. It only changes on a pop, or on
    // the push into an empty FIFO, so the slice holds steady while stalled.
    assign out_data[g*WIDTH +: WIDTH] = out_valid[g] ? mem_q[rd_q] : '0;

    always_comb begin
      cnt_d = cnt_q;
      case ({push[g], pop[g]})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        if (push[g]) begin
          mem_q[wr_q] <= in_data;
          wr_q        <= wr_q + 1'b1;
        end
        if (pop[g]) begin
          rd_q <= rd_q + 1'b1;
        end
      end
    end

`ifdef SPLIT_STATS_EN
    logic [15:0] pkt_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pkt_q <= '0;
      end else if (pop[g]) begin
        pkt_q <= pkt_q + 16'd1;
      end
    end

    assign pkt_count[g*16 +: 16] = pkt_q;
`endif
  end

endmodule

// File: tb/tb_output_split_block.sv
// tb/tb_output_split_block.sv - directed table-driven bench for output_split_block

module tb_output_split_block;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [10:0] in_data;
  logic        in_ready;
  logic [4:0]  out_valid;
  logic [54:0] out_data;
  logic [4:0]  out_ready;
  logic [7:0]  drop_count;
`ifdef SPLIT_STATS_EN
  logic [79:0] pkt_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  output_split_block #(
    .WIDTH   (11),
    .DEST_MSB(10),
    .DEPTH   (2),
    .CNT_W   (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .drop_count(drop_count)
`ifdef SPLIT_STATS_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  typedef struct {
    logic        iv;
    logic [10:0] id;
    logic [4:0]  ordy;
    logic        e_ird;
    logic [4:0]  e_vld;
    logic [54:0] e_data;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vt[22];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [54:0] pk(input logic [10:0] d4, input logic [10:0] d3,
                                     input logic [10:0] d2, input logic [10:0] d1,
                                     input logic [10:0] d0);
    return {d4, d3, d2, d1, d0};
  endfunction

  function automatic vec_t mv(input logic iv, input logic [10:0] id, input logic [4:0] ordy,
                              input logic e_ird, input logic [4:0] e_vld,
                              input logic [54:0] e_data, input logic [7:0] e_drop);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.e_ird = e_ird;
    v.e_vld = e_vld; v.e_data = e_data; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [10:0] id, input logic [4:0] ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 11'h011;
    out_ready = 5'b00000;
    #1;
    chk("in_ready_during_reset", in_ready, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 5'b0);
    chk("reset_out_data", out_data, 55'b0);
    chk("reset_drop", drop_count, 8'd0);
  endtask

  logic [10:0] seq[7];
  logic        bad;
  logic [10:0] prev;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = '0;

    // Each row: inputs driven after a falling edge; expected outputs hold
    // before the following rising edge.
    vt[0]  = mv(1, 11'h1A5, 5'b11111, 1, 5'b00000, pk(0, 0, 0, 0, 0), 0);
    vt[1]  = mv(0, 11'h000, 5'b11111, 1, 5'b00010, pk(0, 0, 0, 11'h1A5, 0), 0);
    vt[2]  = mv(0, 11'h000, 5'b00000, 1, 5'b00000, pk(0, 0, 0, 0, 0), 0);
    vt[3]  = mv(1, 11'h011, 5'b00000, 1, 5'b00000, pk(0, 0, 0, 0, 0), 0);
    vt[4]  = mv(1, 11'h022, 5'b00000, 1, 5'b00001, pk(0, 0, 0, 0, 11'h011), 0);
    vt[5]  = mv(1, 11'h033, 5'b00000, 0, 5'b00001, pk(0, 0, 0, 0, 11'h011), 0);
    vt[6]  = mv(1, 11'h033, 5'b00001, 0, 5'b00001, pk(0, 0, 0, 0, 11'h011), 0);
    vt[7]  = mv(1, 11'h033, 5'b00001, 1, 5'b00001, pk(0, 0, 0, 0, 11'h022), 0);
    vt[8]  = mv(0, 11'h000, 5'b00001, 1, 5'b00001, pk(0, 0, 0, 0, 11'h033), 0);
    vt[9]  = mv(0, 11'h000, 5'b00000, 1, 5'b00000, pk(0, 0, 0, 0, 0), 0);
    vt[10] = mv(1, 11'h2AA, 5'b00000, 1, 5'b00000, pk(0, 0, 0, 0, 0), 0);
    vt[11] = mv(1, 11'h255, 5'b00000, 1, 5'b00100, pk(0, 0, 11'h2AA, 0, 0), 0);
    vt[12] = mv(1, 11'h2EE, 5'b00000, 0, 5'b00100, pk(0, 0, 11'h2AA, 0, 0), 0);
    vt[13] = mv(1, 11'h400, 5'b10000, 1, 5'b00100, pk(0, 0, 11'h2AA, 0, 0), 0);
    vt[14] = mv(1, 11'h401, 5'b10000, 1, 5'b10100, pk(11'h400, 0, 11'h2AA, 0, 0), 0);
    vt[15] = mv(0, 11'h000, 5'b10000, 1, 5'b10100, pk(11'h401, 0, 11'h2AA, 0, 0), 0);
    vt[16] = mv(0, 11'h000, 5'b00100, 1, 5'b00100, pk(0, 0, 11'h2AA, 0, 0), 0);
    vt[17] = mv(0, 11'h000, 5'b00100, 1, 5'b00100, pk(0, 0, 11'h255, 0, 0), 0);
    vt[18] = mv(1, 11'h600, 5'b00000, 1, 5'b00000, pk(0, 0, 0, 0, 0), 0);
    vt[19] = mv(1, 11'h500, 5'b00000, 1, 5'b00000, pk(0, 0, 0, 0, 0), 1);
    vt[20] = mv(1, 11'h7FF, 5'b00000, 1, 5'b00000, pk(0, 0, 0, 0, 0), 2);
    vt[21] = mv(0, 11'h000, 5'b00000, 1, 5'b00000, pk(0, 0, 0, 0, 0), 3);

    do_reset();

    for (int i = 0; i < 22; i++) begin
      drive(vt[i].iv, vt[i].id, vt[i].ordy);
      chk($sformatf("v%0d_in_ready", i), in_ready, vt[i].e_ird);
      chk($sformatf("v%0d_out_valid", i), out_valid, vt[i].e_vld);
      chk($sformatf("v%0d_out_data", i), out_data, vt[i].e_data);
      chk($sformatf("v%0d_drop", i), drop_count, vt[i].e_drop);
    end

    // 297 further invalid packets (300 in total) saturate the counter at 255.
    bad = 1'b0;
    for (int i = 0; i < 297; i++) begin
      drive(1'b1, {3'b110, 8'($urandom_range(0, 255))}, 5'b11111);
      if (in_ready !== 1'b1 || out_valid !== 5'b0) bad = 1'b1;
    end
    chk("drop_stream_ready", bad, 1'b0);
    drive(1'b0, 11'h000, 5'b11111);
    chk("drop_saturated", drop_count, 8'd255);
    chk("drop_no_valid", out_valid, 5'b0);
    drive(1'b1, 11'h700, 5'b11111);
    drive(1'b0, 11'h000, 5'b11111);
    chk("drop_no_wrap", drop_count, 8'd255);

    // Reset in the middle of operation with FIFOs 0 and 3 holding packets.
    drive(1'b1, 11'h0C3, 5'b00000);
    drive(1'b1, 11'h3C3, 5'b00000);
    drive(1'b0, 11'h000, 5'b00000);
    chk("midrst_pre_valid", out_valid, 5'b01001);
    do_reset();
    drive(1'b1, 11'h1F0, 5'b11111);
    chk("midrst_post_empty", out_valid, 5'b0);
    drive(1'b0, 11'h000, 5'b11111);
    chk("midrst_only_valid", out_valid, 5'b00010);
    chk("midrst_only_data", out_data, pk(0, 0, 0, 11'h1F0, 0));
    drive(1'b0, 11'h000, 5'b11111);
    chk("midrst_drained", out_valid, 5'b0);

    // Five port-3 packets then two core packets, outputs always ready.
    do_reset();
    seq[0] = 11'h300; seq[1] = 11'h301; seq[2] = 11'h302; seq[3] = 11'h303;
    seq[4] = 11'h304; seq[5] = 11'h410; seq[6] = 11'h411;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k < 7) drive(1'b1, seq[k], 5'b11111);
      else       drive(1'b0, 11'h000, 5'b11111);
      if (k < 7 && in_ready !== 1'b1) bad = 1'b1;
      if (k > 0) begin
        prev = seq[k-1];
        if (out_valid !== (5'b00001 << prev[10:8])) bad = 1'b1;
        if (out_data[prev[10:8]*11 +: 11] !== prev) bad = 1'b1;
      end
    end
    chk("stream_order", bad, 1'b0);
    drive(1'b0, 11'h000, 5'b11111);
    chk("stream_drained", out_valid, 5'b0);
`ifdef SPLIT_STATS_EN
    chk("pkt_count", pkt_count, {16'd2, 16'd5, 16'd0, 16'd0, 16'd0});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
